axi4_lite_single_master: RTL and testbench
==========================================

Name: axi4_lite_single_master

Overview:
Single-outstanding AXI4-Lite master that converts a simple command/response interface into AXI4-Lite read and write transactions. It sits directly upstream of the team's AXI4-Lite slave blocks and drives their AW/W/B/AR/R channels. It is intended for register-access engines, test sequencers and bridge front-ends.

Parameters:
ADDR_W, 32, width of the AXI address and command address
DATA_W, 32, data width; must be 32 or 64
TIMEOUT_CYCLES, 256, watchdog limit in cycles; used only with the optional feature

Ports:
i_ACLK  in  1  clock
i_ARESETN  in  1  asynchronous active-low reset
i_CMD_VALID  in  1  command request
o_CMD_READY  out  1  command accepted when high together with i_CMD_VALID
i_CMD_WRITE  in  1  1 = write, 0 = read
i_CMD_ADDR  in  ADDR_W  byte address
i_CMD_WDATA  in  DATA_W  write data
i_CMD_WSTRB  in  DATA_W/8  write byte strobes
o_RSP_VALID  out  1  response available
i_RSP_READY  in  1  response consumed
o_RSP_RDATA  out  DATA_W  read data; 0 for writes
o_RSP_RESP  out  2  captured BRESP or RRESP
o_M_AWADDR/o_M_AWPROT/o_M_AWVALID  out  ADDR_W/3/1; i_S_AWREADY  in  1
o_M_WDATA/o_M_WSTRB/o_M_WVALID  out  DATA_W/DATA_W/8/1; i_S_WREADY  in  1
i_S_BRESP  in  2; i_S_BVALID  in  1; o_M_BREADY  out  1
o_M_ARADDR/o_M_ARPROT/o_M_ARVALID  out  ADDR_W/3/1; i_S_ARREADY  in  1
i_S_RDATA  in  DATA_W; i_S_RRESP  in  2; i_S_RVALID  in  1; o_M_RREADY  out  1

Behaviour:
- Clocking and reset: one clock, i_ACLK. Reset i_ARESETN is asynchronous and active-low.
- While reset is asserted:
  - all VALID/READY outputs and o_RSP_VALID are 0;
  - address, data, strobe, RDATA and RESP registers are 0;
  - FSM is in IDLE.
- All outputs are registered. AWPROT and ARPROT are fixed at 3'b000.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE:
  - o_CMD_READY=1 only in IDLE and only when reset is deasserted.
  - On the cycle where i_CMD_VALID and o_CMD_READY are both high, the command is captured.
  - Next state is WR_REQ if i_CMD_WRITE=1, else RD_REQ.
- WR_REQ:
  - AWVALID and WVALID both rise in the cycle after command acceptance.
  - Each VALID stays high, with its payload stable, until its own handshake. The two handshakes may occur in either order or in the same cycle.
  - Two internal done flags track acceptance.
  - Once both channels are done, go to WR_RESP with BREADY=1.
- WR_RESP: on BVALID&&BREADY, capture BRESP, set o_RSP_RDATA=0, drop BREADY, go to RSP.
- RD_REQ: ARVALID is held until ARREADY, then go to RD_DATA with RREADY=1.
- RD_DATA: on RVALID&&RREADY, capture RDATA and RRESP, drop RREADY, go to RSP.
- RSP: o_RSP_VALID is held with stable data until i_RSP_READY, then go to IDLE. The next command is accepted no earlier than the following cycle.
- Latency (slave always ready, zero-wait B/R):
  - command accepted at N, AW/W or AR handshake at N+1;
  - B or R handshake at N+2;
  - o_RSP_VALID high at N+3.
- Boundaries:
  - Only one transaction is outstanding at any time.
  - Stray B/R beats arriving outside WR_RESP/RD_DATA are not accepted (READY=0).
  - Reset mid-transaction aborts immediately: VALIDs drop asynchronously and the pending command and response are discarded.

Optional Feature:
AXI4_LITE_MASTER_TIMEOUT_EN
- When defined:
  - adds output o_TIMEOUT (1 bit, sticky);
  - a counter clears on every state change and increments in every non-IDLE, non-RSP state;
  - when it reaches TIMEOUT_CYCLES, o_TIMEOUT is set and stays set until reset;
  - the AXI transaction is not aborted, which keeps the channels protocol-legal.
- When undefined: no counter and no port. Behaviour is otherwise identical.

Decomposition:
- Package axi4_lite_pkg holds:
  - response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - constant PROT_DEFAULT=3'b000;
  - the master FSM state encoding.
- One sub-module is natural: axi4_lite_watchdog (counter plus sticky flag), instantiated only under the macro.

Test Plan:
- Write, slave always ready: CMD write addr 0x0000_0010, data 0xDEADBEEF, strb 4'hF; BRESP=00 -> AW/W beats carry 0x10/0xDEADBEEF at N+1, o_RSP_VALID at N+3 with RESP=00, RDATA=0.
- Read with wait states: CMD read addr 0x20; ARREADY delayed 3 cycles, RVALID delayed 2 cycles with RDATA=0x12345678, RRESP=00 -> ARADDR stable until handshake, RSP RDATA=0x12345678.
- Skewed write channels: WREADY at N+1, AWREADY at N+4 -> WVALID drops after N+1, AWVALID holds to N+4, BREADY rises at N+5.
- Error and backpressure: BRESP=2'b10 and i_RSP_READY held low 5 cycles -> o_RSP_VALID and RESP=10 stable throughout, o_CMD_READY=0 until release.
- Reset mid-read: assert i_ARESETN=0 while ARVALID=1 -> ARVALID, o_RSP_VALID and o_CMD_READY go to 0 without a clock edge; after release o_CMD_READY=1 on the first edge.
- Macro defined, TIMEOUT_CYCLES=8, AWREADY never asserted -> o_TIMEOUT=1 after 8 cycles in WR_REQ and stays set after AWREADY finally arrives.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite constants: response codes, default protection and the
// single-master FSM state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_REQ  = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_REQ  = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_RSP     = 3'd5;

  // States in which the master is waiting on the slave.
  function automatic logic st_on_bus(input logic [2:0] st);
    return (st == ST_WR_REQ) || (st == ST_WR_RESP) ||
           (st == ST_RD_REQ) || (st == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/axi4_lite_watchdog.sv
// Bus-wait watchdog: counts cycles spent in one waiting state and raises a
// sticky flag once the limit is reached. Built only with AXI4_LITE_MASTER_TIMEOUT_EN.
module axi4_lite_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic i_ACLK,
  input  logic i_ARESETN,
  input  logic i_STATE_CHG,
  input  logic i_ACTIVE,
  output logic o_TIMEOUT
);

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_ACLK or negedge i_ARESETN) begin
    if (!i_ARESETN) begin
      cnt       <= '0;
      o_TIMEOUT <= 1'b0;
    end else begin
      if (i_STATE_CHG)
        cnt <= '0;
      else if (i_ACTIVE && cnt != LIMIT)
        cnt <= cnt + 1'b1;
      // Flag rises on the same edge the count reaches the limit.
      if (i_ACTIVE && !i_STATE_CHG && cnt == LIMIT_M1)
        o_TIMEOUT <= 1'b1;
    end
  end

endmodule

// File: rtl/axi4_lite_single_master.sv
// Single-outstanding AXI4-Lite master: command/response front end to AW/W/B/AR/R.
// Optional watchdog output o_TIMEOUT when AXI4_LITE_MASTER_TIMEOUT_EN is defined.
module axi4_lite_single_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                i_ACLK,
  input  logic                i_ARESETN,
  input  logic                i_CMD_VALID,
  output logic                o_CMD_READY,
  input  logic                i_CMD_WRITE,
  input  logic [ADDR_W-1:0]   i_CMD_ADDR,
  input  logic [DATA_W-1:0]   i_CMD_WDATA,
  input  logic [DATA_W/8-1:0] i_CMD_WSTRB,
  output logic                o_RSP_VALID,
  input  logic                i_RSP_READY,
  output logic [DATA_W-1:0]   o_RSP_RDATA,
  output logic [1:0]          o_RSP_RESP,
  output logic [ADDR_W-1:0]   o_M_AWADDR,
  output logic [2:0]          o_M_AWPROT,
  output logic                o_M_AWVALID,
  input  logic                i_S_AWREADY,
  output logic [DATA_W-1:0]   o_M_WDATA,
  output logic [DATA_W/8-1:0] o_M_WSTRB,
  output logic                o_M_WVALID,
  input  logic                i_S_WREADY,
  input  logic [1:0]          i_S_BRESP,
  input  logic                i_S_BVALID,
  output logic                o_M_BREADY,
  output logic [ADDR_W-1:0]   o_M_ARADDR,
  output logic [2:0]          o_M_ARPROT,
  output logic                o_M_ARVALID,
  input  logic                i_S_ARREADY,
  input  logic [DATA_W-1:0]   i_S_RDATA,
  input  logic [1:0]          i_S_RRESP,
  input  logic                i_S_RVALID,
  output logic                o_M_RREADY
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  , output logic              o_TIMEOUT
`endif
);

  if ((DATA_W != 32 && DATA_W != 64) || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("axi4_lite_single_master: DATA_W must be 32 or 64, TIMEOUT_CYCLES >= 1");
  end

  logic [2:0] state, state_nxt;
  logic       aw_done, w_done;
  logic       cmd_acc, aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_ok, w_ok;

  assign o_M_AWPROT = PROT_DEFAULT;
  assign o_M_ARPROT = PROT_DEFAULT;

  assign cmd_acc = i_CMD_VALID && o_CMD_READY;
  assign aw_hs   = o_M_AWVALID && i_S_AWREADY;
  assign w_hs    = o_M_WVALID  && i_S_WREADY;
  assign b_hs    = i_S_BVALID  && o_M_BREADY;
  assign ar_hs   = o_M_ARVALID && i_S_ARREADY;
  assign r_hs    = i_S_RVALID  && o_M_RREADY;
  // A write channel counts as done if it finished earlier or handshakes now.
  assign aw_ok   = aw_done || aw_hs;
  assign w_ok    = w_done  || w_hs;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (cmd_acc) state_nxt = i_CMD_WRITE ? ST_WR_REQ : ST_RD_REQ;
      ST_WR_REQ:  if (aw_ok && w_ok) state_nxt = ST_WR_RESP;
      ST_WR_RESP: if (b_hs) state_nxt = ST_RSP;
      ST_RD_REQ:  if (ar_hs) state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (r_hs) state_nxt = ST_RSP;
      ST_RSP:     if (i_RSP_READY) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_ACLK or negedge i_ARESETN) begin
    if (!i_ARESETN) begin
      state       <= ST_IDLE;
      o_CMD_READY <= 1'b0;
      o_RSP_VALID <= 1'b0;
      o_RSP_RDATA <= '0;
      o_RSP_RESP  <= RESP_OKAY;
      o_M_AWADDR  <= '0;
      o_M_AWVALID <= 1'b0;
      o_M_WDATA   <= '0;
      o_M_WSTRB   <= '0;
      o_M_WVALID  <= 1'b0;
      o_M_BREADY  <= 1'b0;
      o_M_ARADDR  <= '0;
      o_M_ARVALID <= 1'b0;
      o_M_RREADY  <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      state       <= state_nxt;
      // Ready is registered off the next state, so a new command is taken
      // at the earliest one cycle after the response handshake.
      o_CMD_READY <= (state_nxt == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (cmd_acc && i_CMD_WRITE) begin
            o_M_AWADDR  <= i_CMD_ADDR;
            o_M_WDATA   <= i_CMD_WDATA;
            o_M_WSTRB   <= i_CMD_WSTRB;
            o_M_AWVALID <= 1'b1;
            o_M_WVALID  <= 1'b1;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
          end else if (cmd_acc) begin
            o_M_ARADDR  <= i_CMD_ADDR;
            o_M_ARVALID <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          if (aw_hs) begin
            o_M_AWVALID <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            o_M_WVALID <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_ok && w_ok) o_M_BREADY <= 1'b1;
        end
        ST_WR_RESP: begin
          if (b_hs) begin
            o_M_BREADY  <= 1'b0;
            o_RSP_RDATA <= '0;
            o_RSP_RESP  <= i_S_BRESP;
            o_RSP_VALID <= 1'b1;
          end
        end
        ST_RD_REQ: begin
          if (ar_hs) begin
            o_M_ARVALID <= 1'b0;
            o_M_RREADY  <= 1'b1;
          end
        end
        ST_RD_DATA: begin
          if (r_hs) begin
            o_M_RREADY  <= 1'b0;
            o_RSP_RDATA <= i_S_RDATA;
            o_RSP_RESP  <= i_S_RRESP;
            o_RSP_VALID <= 1'b1;
          end
        end
        ST_RSP: begin
          if (i_RSP_READY) o_RSP_VALID <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  axi4_lite_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_ACLK      (i_ACLK),
    .i_ARESETN   (i_ARESETN),
    .i_STATE_CHG (state != state_nxt),
    .i_ACTIVE    (st_on_bus(state)),
    .o_TIMEOUT   (o_TIMEOUT)
  );
`endif

endmodule

// File: tb/tb_axi4_lite_single_master.sv
// Bench for axi4_lite_single_master: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model of the master.
module tb_axi4_lite_single_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SW     = DATA_W / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              i_CMD_VALID, i_CMD_WRITE, i_RSP_READY;
  logic [ADDR_W-1:0] i_CMD_ADDR;
  logic [DATA_W-1:0] i_CMD_WDATA, i_S_RDATA;
  logic [SW-1:0]     i_CMD_WSTRB;
  logic              i_S_AWREADY, i_S_WREADY, i_S_BVALID, i_S_ARREADY, i_S_RVALID;
  logic [1:0]        i_S_BRESP, i_S_RRESP;
  logic              o_CMD_READY, o_RSP_VALID;
  logic [DATA_W-1:0] o_RSP_RDATA, o_M_WDATA;
  logic [1:0]        o_RSP_RESP;
  logic [ADDR_W-1:0] o_M_AWADDR, o_M_ARADDR;
  logic [2:0]        o_M_AWPROT, o_M_ARPROT;
  logic [SW-1:0]     o_M_WSTRB;
  logic              o_M_AWVALID, o_M_WVALID, o_M_BREADY, o_M_ARVALID, o_M_RREADY;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  logic              o_TIMEOUT;
`endif

  axi4_lite_single_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)
  ) dut (
    .i_ACLK(clk), .i_ARESETN(rst_n),
    .i_CMD_VALID(i_CMD_VALID), .o_CMD_READY(o_CMD_READY), .i_CMD_WRITE(i_CMD_WRITE),
    .i_CMD_ADDR(i_CMD_ADDR), .i_CMD_WDATA(i_CMD_WDATA), .i_CMD_WSTRB(i_CMD_WSTRB),
    .o_RSP_VALID(o_RSP_VALID), .i_RSP_READY(i_RSP_READY),
    .o_RSP_RDATA(o_RSP_RDATA), .o_RSP_RESP(o_RSP_RESP),
    .o_M_AWADDR(o_M_AWADDR), .o_M_AWPROT(o_M_AWPROT), .o_M_AWVALID(o_M_AWVALID),
    .i_S_AWREADY(i_S_AWREADY),
    .o_M_WDATA(o_M_WDATA), .o_M_WSTRB(o_M_WSTRB), .o_M_WVALID(o_M_WVALID),
    .i_S_WREADY(i_S_WREADY),
    .i_S_BRESP(i_S_BRESP), .i_S_BVALID(i_S_BVALID), .o_M_BREADY(o_M_BREADY),
    .o_M_ARADDR(o_M_ARADDR), .o_M_ARPROT(o_M_ARPROT), .o_M_ARVALID(o_M_ARVALID),
    .i_S_ARREADY(i_S_ARREADY),
    .i_S_RDATA(i_S_RDATA), .i_S_RRESP(i_S_RRESP), .i_S_RVALID(i_S_RVALID),
    .o_M_RREADY(o_M_RREADY)
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    , .o_TIMEOUT(o_TIMEOUT)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding command and which of its
  // phases have completed so far.
  bit                m_fresh, m_pend, m_wr, m_aw, m_w, m_b, m_ar, m_r;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [SW-1:0]     m_strb;
  logic [1:0]        m_resp;

  always @(negedge clk) begin
    bit e_cmd, e_aw, e_w, e_b, e_ar, e_r, e_rsp;
    if (!rst_n) begin
      m_fresh = 1; m_pend = 0;
      chk("rst_cmd_ready", 64'(o_CMD_READY), 64'd0);
      chk("rst_rsp_valid", 64'(o_RSP_VALID), 64'd0);
      chk("rst_valids", 64'({o_M_AWVALID, o_M_WVALID, o_M_ARVALID}), 64'd0);
      chk("rst_readies", 64'({o_M_BREADY, o_M_RREADY}), 64'd0);
      chk("rst_addr", 64'({o_M_AWADDR, o_M_ARADDR}), 64'd0);
      chk("rst_wdata_strb", 64'({o_M_WDATA, o_M_WSTRB}), 64'd0);
      chk("rst_rsp_data", 64'({o_RSP_RDATA, o_RSP_RESP}), 64'd0);
    end else begin
      e_cmd = !m_pend && !m_fresh;
      e_aw  = m_pend && m_wr && !m_aw;
      e_w   = m_pend && m_wr && !m_w;
      e_b   = m_pend && m_wr && m_aw && m_w && !m_b;
      e_ar  = m_pend && !m_wr && !m_ar;
      e_r   = m_pend && !m_wr && m_ar && !m_r;
      e_rsp = m_pend && (m_b || m_r);
      chk("cmd_ready", 64'(o_CMD_READY), 64'(e_cmd));
      chk("awvalid",   64'(o_M_AWVALID), 64'(e_aw));
      chk("wvalid",    64'(o_M_WVALID),  64'(e_w));
      chk("bready",    64'(o_M_BREADY),  64'(e_b));
      chk("arvalid",   64'(o_M_ARVALID), 64'(e_ar));
      chk("rready",    64'(o_M_RREADY),  64'(e_r));
      chk("rsp_valid", 64'(o_RSP_VALID), 64'(e_rsp));
      chk("prot", 64'({o_M_AWPROT, o_M_ARPROT}), 64'd0);
      if (e_aw)  chk("awaddr", 64'(o_M_AWADDR), 64'(m_addr));
      if (e_w)   chk("wdata_strb", 64'({o_M_WDATA, o_M_WSTRB}), 64'({m_wdata, m_strb}));
      if (e_ar)  chk("araddr", 64'(o_M_ARADDR), 64'(m_addr));
      if (e_rsp) chk("rsp_rdata", 64'(o_RSP_RDATA), 64'(m_rdata));
      if (e_rsp) chk("rsp_resp", 64'(o_RSP_RESP), 64'(m_resp));
      // Advance the model by what happens at the coming clock edge.
      m_fresh = 0;
      if (e_rsp && i_RSP_READY) m_pend = 0;
      else if (e_cmd && i_CMD_VALID) begin
        m_pend = 1; m_wr = i_CMD_WRITE; m_addr = i_CMD_ADDR;
        m_wdata = i_CMD_WDATA; m_strb = i_CMD_WSTRB;
        m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0;
      end else begin
        if (e_aw && i_S_AWREADY) m_aw = 1;
        if (e_w && i_S_WREADY)   m_w = 1;
        if (e_b && i_S_BVALID) begin m_b = 1; m_rdata = '0; m_resp = i_S_BRESP; end
        if (e_ar && i_S_ARREADY) m_ar = 1;
        if (e_r && i_S_RVALID) begin m_r = 1; m_rdata = i_S_RDATA; m_resp = i_S_RRESP; end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!o_CMD_READY && n < 50) begin tick(); n++; end
    chk(nm, 64'(o_CMD_READY), 64'd1);
  endtask

  task automatic send(input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [SW-1:0] s);
    i_CMD_VALID = 1; i_CMD_WRITE = wr; i_CMD_ADDR = a; i_CMD_WDATA = d; i_CMD_WSTRB = s;
    tick();
    i_CMD_VALID = 0;
  endtask

  task automatic slave_ready();
    i_S_AWREADY = 1; i_S_WREADY = 1; i_S_BVALID = 1; i_S_BRESP = 2'b00;
    i_S_ARREADY = 1; i_S_RVALID = 1; i_S_RRESP = 2'b00; i_S_RDATA = '0;
    i_RSP_READY = 1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    i_CMD_VALID = 0; i_CMD_WRITE = 0; i_CMD_ADDR = '0; i_CMD_WDATA = '0; i_CMD_WSTRB = '0;
    i_RSP_READY = 0; i_S_AWREADY = 0; i_S_WREADY = 0; i_S_BVALID = 0; i_S_BRESP = 0;
    i_S_ARREADY = 0; i_S_RVALID = 0; i_S_RRESP = 0; i_S_RDATA = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("cmd_ready_before_first_edge", 64'(o_CMD_READY), 64'd0);

    // Zero-wait write: AW/W at N+1, B at N+2, response at N+3.
    slave_ready();
    wait_ready("wr_cmd_ready");
    send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    chk("wr_awvalid_n1", 64'(o_M_AWVALID), 64'd1);
    chk("wr_awaddr_n1", 64'(o_M_AWADDR), 64'h10);
    chk("wr_wdata_n1", 64'(o_M_WDATA), 64'hDEAD_BEEF);
    tick();
    chk("wr_bready_n2", 64'(o_M_BREADY), 64'd1);
    tick();
    chk("wr_rsp_valid_n3", 64'(o_RSP_VALID), 64'd1);
    chk("wr_rsp_resp_n3", 64'(o_RSP_RESP), 64'd0);
    chk("wr_rsp_rdata_n3", 64'(o_RSP_RDATA), 64'd0);
    tick();
    chk("wr_rsp_done", 64'({o_RSP_VALID, o_CMD_READY}), 64'b01);

    // Read with ARREADY delayed 3 cycles and RVALID delayed 2 cycles.
    i_S_ARREADY = 0; i_S_RVALID = 0;
    wait_ready("rd_cmd_ready");
    send(1'b0, 32'h0000_0020, '0, '0);
    for (int k = 0; k < 3; k++) begin
      chk("rd_araddr_hold", 64'({o_M_ARVALID, o_M_ARADDR}), {31'd0, 1'b1, 32'h20});
      tick();
    end
    i_S_ARREADY = 1;
    chk("rd_arvalid_n4", 64'(o_M_ARVALID), 64'd1);
    tick();
    i_S_ARREADY = 0;
    chk("rd_rready_n5", 64'({o_M_RREADY, o_M_ARVALID}), 64'b10);
    tick();
    tick();
    i_S_RVALID = 1; i_S_RDATA = 32'h1234_5678;
    tick();
    i_S_RVALID = 0;
    chk("rd_rsp_valid", 64'(o_RSP_VALID), 64'd1);
    chk("rd_rsp_rdata", 64'(o_RSP_RDATA), 64'h1234_5678);
    tick();

    // Skewed write channels: W at N+1, AW at N+4, BREADY at N+5.
    slave_ready(); i_S_AWREADY = 0;
    wait_ready("skew_cmd_ready");
    send(1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4'hA);
    chk("skew_both_valid_n1", 64'({o_M_AWVALID, o_M_WVALID}), 64'b11);
    tick();
    i_S_WREADY = 0;
    chk("skew_w_dropped_n2", 64'({o_M_AWVALID, o_M_WVALID}), 64'b10);
    tick();
    tick();
    i_S_AWREADY = 1;
    chk("skew_n4", 64'({o_M_AWVALID, o_M_BREADY}), 64'b10);
    tick();
    i_S_AWREADY = 0;
    chk("skew_bready_n5", 64'({o_M_AWVALID, o_M_BREADY}), 64'b01);
    tick();
    chk("skew_rsp_n6", 64'(o_RSP_VALID), 64'd1);
    tick();

    // SLVERR with response backpressure.
    slave_ready(); i_S_BRESP = 2'b10; i_RSP_READY = 0;
    wait_ready("err_cmd_ready");
    send(1'b1, 32'h0000_0044, 32'h5A5A_0F0F, 4'h3);
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("err_rsp_hold", 64'({o_RSP_VALID, o_RSP_RESP, o_CMD_READY}), 64'b1100);
      tick();
    end
    i_RSP_READY = 1;
    chk("err_rsp_still", 64'({o_RSP_VALID, o_RSP_RESP}), 64'b110);
    tick();
    chk("err_released", 64'({o_RSP_VALID, o_CMD_READY}), 64'b01);

    // Asynchronous reset while ARVALID is high.
    slave_ready(); i_S_ARREADY = 0;
    wait_ready("rst_cmd_ready_pre");
    send(1'b0, 32'h0000_0030, '0, '0);
    tick();
    chk("rst_mid_arvalid_pre", 64'(o_M_ARVALID), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_async", 64'({o_M_ARVALID, o_RSP_VALID, o_CMD_READY, o_M_RREADY}), 64'd0);
    chk("rst_mid_araddr", 64'(o_M_ARADDR), 64'd0);
    tick();
    tick();
    rst_n = 1;
    chk("rst_rel_no_edge", 64'(o_CMD_READY), 64'd0);
    tick();
    chk("rst_rel_first_edge", 64'({o_CMD_READY, o_M_ARVALID}), 64'b10);

    // Randomized traffic with a randomly stalling slave and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      i_CMD_VALID = ($urandom_range(2) == 0);
      i_CMD_WRITE = 1'($urandom);
      i_CMD_ADDR  = ADDR_W'($urandom);
      i_CMD_WDATA = DATA_W'($urandom);
      i_CMD_WSTRB = SW'($urandom);
      i_RSP_READY = 1'($urandom);
      i_S_AWREADY = ($urandom_range(2) != 0);
      i_S_WREADY  = ($urandom_range(2) != 0);
      i_S_ARREADY = ($urandom_range(2) != 0);
      i_S_BVALID  = 1'($urandom);
      i_S_BRESP   = 2'($urandom);
      i_S_RVALID  = 1'($urandom);
      i_S_RRESP   = 2'($urandom);
      i_S_RDATA   = DATA_W'($urandom);
      rst_n       = ($urandom_range(399) != 0);
      tick();
    end
    rst_n = 1;
    i_CMD_VALID = 0;
    tick();

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    // Watchdog: AW never ready, flag after 8 cycles in WR_REQ, sticky afterwards.
    rst_n = 0;
    tick();
    chk("to_reset_clear", 64'(o_TIMEOUT), 64'd0);
    rst_n = 1;
    slave_ready(); i_S_AWREADY = 0;
    tick();
    wait_ready("to_cmd_ready");
    send(1'b1, 32'h0000_0100, 32'h0BAD_F00D, 4'hF);
    repeat (7) tick();
    chk("to_n8_clear", 64'(o_TIMEOUT), 64'd0);
    tick();
    chk("to_n9_set", 64'(o_TIMEOUT), 64'd1);
    i_S_AWREADY = 1;
    repeat (4) tick();
    chk("to_sticky", 64'({o_TIMEOUT, o_CMD_READY}), 64'b11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
